// File: rtl/bmp_result_writer.sv
// bmp_result_writer: copies the BMP header from the source ROM into the result
// RAM, then stores each valid filtered pixel after the header. header_done tells
// the filter to start streaming, and write_done tells the controller that a full
// frame has been stored.
module bmp_result_writer #(
   parameter int BIT_WIDTH  = 8,
   parameter int ADDR_WIDTH = 14,
   parameter int HEADER_LEN = 1078,
   parameter int PIXELS     = 10000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic [ADDR_WIDTH-1:0] hdr_addr,
   input  logic [BIT_WIDTH-1:0]  hdr_data,
   output logic                  header_done,
   input  logic [BIT_WIDTH-1:0]  pixel_in,
   input  logic                  pixel_valid,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [BIT_WIDTH-1:0]  mem_din,
   output logic                  busy,
   output logic                  write_done
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_HDR  = 2'd1;
   localparam logic [1:0] ST_PIX  = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Pixel counter is sized to hold PIXELS itself, so it can never wrap.
   localparam int PCW = $clog2(PIXELS + 1);

   localparam logic [ADDR_WIDTH-1:0] HDR_BASE = ADDR_WIDTH'(HEADER_LEN);
   localparam logic [ADDR_WIDTH-1:0] HDR_LAST = ADDR_WIDTH'(HEADER_LEN - 1);
   localparam logic [PCW-1:0]        PIX_LAST = PCW'(PIXELS - 1);

   // The whole frame must fit in the result RAM address space.
   if (HEADER_LEN + PIXELS > (1 << ADDR_WIDTH)) begin : g_range_err
      $error("bmp_result_writer: HEADER_LEN+PIXELS exceeds the address space");
   end

   logic [1:0]            state_r;
   logic [PCW-1:0]        pix_cnt_r;
   // Header read pipeline: stage 1 holds the address presented to the ROM this
   // cycle. Stage 2 marks the cycle in which the ROM data for that address is
   // on hdr_data.
   logic                  rd_v1_r;
   logic                  rd_v2_r;
   logic [ADDR_WIDTH-1:0] rd_addr2_r;

   // Frame sequencer: header copy, pixel capture and completion, with all outputs registered.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         pix_cnt_r   <= '0;
         rd_v1_r     <= 1'b0;
         rd_v2_r     <= 1'b0;
         rd_addr2_r  <= '0;
         hdr_addr    <= '0;
         header_done <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= '0;
         mem_din     <= '0;
         busy        <= 1'b0;
         write_done  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_DONE: begin
               // The sequencer is parked here, so pixel_valid is ignored.
               mem_we  <= 1'b0;
               rd_v2_r <= 1'b0;
               if (start) begin
                  state_r     <= ST_HDR;
                  busy        <= 1'b1;
                  hdr_addr    <= '0;
                  header_done <= 1'b0;
                  write_done  <= 1'b0;
                  pix_cnt_r   <= '0;
                  rd_v1_r     <= 1'b1;
               end else if (state_r == ST_DONE) begin
                  busy       <= 1'b0;
                  write_done <= 1'b1;
                  rd_v1_r    <= 1'b0;
               end else begin
                  rd_v1_r <= 1'b0;
               end
            end
            ST_HDR: begin
               // Step the ROM address up to the last header byte, then hold it there.
               rd_v2_r    <= rd_v1_r;
               rd_addr2_r <= hdr_addr;
               if (hdr_addr != HDR_LAST) begin
                  hdr_addr <= hdr_addr + ADDR_WIDTH'(1);
                  rd_v1_r  <= 1'b1;
               end else begin
                  rd_v1_r <= 1'b0;
               end
               // ROM data is on hdr_data now, so write it two cycles after its address.
               if (rd_v2_r) begin
                  mem_we   <= 1'b1;
                  mem_addr <= rd_addr2_r;
                  mem_din  <= hdr_data;
               end else if (mem_we && (mem_addr == HDR_LAST)) begin
                  mem_we      <= 1'b0;
                  header_done <= 1'b1;
                  state_r     <= ST_PIX;
               end else begin
                  mem_we <= 1'b0;
               end
            end
            ST_PIX: begin
               if (pixel_valid) begin
                  mem_we    <= 1'b1;
                  mem_addr  <= HDR_BASE + ADDR_WIDTH'(pix_cnt_r);
                  mem_din   <= pixel_in;
                  pix_cnt_r <= pix_cnt_r + PCW'(1);
                  if (pix_cnt_r == PIX_LAST) begin
                     state_r <= ST_DONE;
                  end
               end else begin
                  mem_we <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               mem_we  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bmp_result_writer.sv
// Directed self-checking bench for bmp_result_writer. It uses a default-size
// instance for the full-frame tests and a small instance (HEADER_LEN=4,
// PIXELS=6) for the gapped-stream and overrun test.
module tb_bmp_result_writer;

   logic        clk;
   logic        rst_n;
   int          checks;
   int          errors;

   // default-size instance
   logic        start;
   logic [13:0] hdr_addr;
   logic [7:0]  hdr_data;
   logic        header_done;
   logic [7:0]  pixel_in;
   logic        pixel_valid;
   logic        mem_we;
   logic [13:0] mem_addr;
   logic [7:0]  mem_din;
   logic        busy;
   logic        write_done;

   // small instance
   logic        s_start;
   logic [13:0] s_hdr_addr;
   logic [7:0]  s_hdr_data;
   logic        s_header_done;
   logic [7:0]  s_pixel_in;
   logic        s_pixel_valid;
   logic        s_mem_we;
   logic [13:0] s_mem_addr;
   logic [7:0]  s_mem_din;
   logic        s_busy;
   logic        s_write_done;

   bmp_result_writer dut (
      .clk(clk), .rst_n(rst_n), .start(start), .hdr_addr(hdr_addr),
      .hdr_data(hdr_data), .header_done(header_done), .pixel_in(pixel_in),
      .pixel_valid(pixel_valid), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_din(mem_din), .busy(busy), .write_done(write_done)
   );

   bmp_result_writer #(.BIT_WIDTH(8), .ADDR_WIDTH(14), .HEADER_LEN(4), .PIXELS(6)) dut_s (
      .clk(clk), .rst_n(rst_n), .start(s_start), .hdr_addr(s_hdr_addr),
      .hdr_data(s_hdr_data), .header_done(s_header_done), .pixel_in(s_pixel_in),
      .pixel_valid(s_pixel_valid), .mem_we(s_mem_we), .mem_addr(s_mem_addr),
      .mem_din(s_mem_din), .busy(s_busy), .write_done(s_write_done)
   );

   // clock generation
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous source ROMs: byte = addr[7:0] (small ROM XORs it with A0)
   always_ff @(posedge clk) begin
      hdr_data   <= hdr_addr[7:0];
      s_hdr_data <= s_hdr_addr[7:0] ^ 8'hA0;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_hdr_addr"}, 32'(hdr_addr), 32'd0);
      chk({tag, "_header_done"}, 32'(header_done), 32'd0);
      chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
      chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
      chk({tag, "_mem_din"}, 32'(mem_din), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_write_done"}, 32'(write_done), 32'd0);
   endtask

   // Start a frame and check the header copy up to header_done. A nonzero
   // abuse_t sends a second start pulse right after hdr_addr reaches abuse_t.
   task automatic run_header(input int abuse_t);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("hs_busy", 32'(busy), 32'd1);
      chk("hs_hdr_addr", 32'(hdr_addr), 32'd0);
      chk("hs_header_done", 32'(header_done), 32'd0);
      chk("hs_write_done", 32'(write_done), 32'd0);
      chk("hs_mem_we", 32'(mem_we), 32'd0);
      for (int t = 1; t <= 1080; t++) begin
         start = (abuse_t != 0) && (t == abuse_t + 1);
         tick();
         start = 1'b0;
         chk("h_hdr_addr", 32'(hdr_addr), (t < 1077) ? 32'(t) : 32'd1077);
         chk("h_mem_we", 32'(mem_we), (t >= 2 && t <= 1079) ? 32'd1 : 32'd0);
         if (t >= 2 && t <= 1079) begin
            chk("h_mem_addr", 32'(mem_addr), 32'(t - 2));
            chk("h_mem_din", 32'(mem_din), 32'((t - 2) & 255));
         end
         chk("h_header_done", 32'(header_done), (t >= 1080) ? 32'd1 : 32'd0);
         chk("h_busy", 32'(busy), 32'd1);
      end
   endtask

   // Stream 10000 back-to-back pixels, then check completion and the overrun guard.
   task automatic run_pixels;
      for (int i = 0; i < 10000; i++) begin
         pixel_valid = 1'b1;
         pixel_in    = 8'(i);
         tick();
         chk("p_mem_we", 32'(mem_we), 32'd1);
         chk("p_mem_addr", 32'(mem_addr), 32'(1078 + i));
         chk("p_mem_din", 32'(mem_din), 32'(i & 255));
         chk("p_write_done", 32'(write_done), 32'd0);
      end
      pixel_valid = 1'b1;
      pixel_in    = 8'h33;
      tick();
      chk("pd_mem_we", 32'(mem_we), 32'd0);
      chk("pd_busy", 32'(busy), 32'd0);
      chk("pd_write_done", 32'(write_done), 32'd1);
      chk("pd_header_done", 32'(header_done), 32'd1);
      tick();
      chk("pd2_mem_we", 32'(mem_we), 32'd0);
      chk("pd2_write_done", 32'(write_done), 32'd1);
      pixel_valid = 1'b0;
   endtask

   int         gaps [6];
   logic [7:0] vals [6];

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      start = 1'b0;
      pixel_valid = 1'b0;
      pixel_in = 8'h00;
      s_start = 1'b0;
      s_pixel_valid = 1'b0;
      s_pixel_in = 8'h00;
      gaps = '{0, 2, 1, 3, 0, 2};
      vals = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};

      // reset, then idle with pixel_valid pulses
      tick();
      tick();
      chk_zero("rst");
      chk("rst_s_busy", 32'(s_busy), 32'd0);
      chk("rst_s_mem_we", 32'(s_mem_we), 32'd0);
      rst_n = 1'b1;
      pixel_valid = 1'b1;
      pixel_in = 8'h55;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk_zero("idle");
      end
      pixel_valid = 1'b0;

      // small instance: header copy, then gapped stream with overrun
      s_start = 1'b1;
      tick();
      s_start = 1'b0;
      chk("s_busy", 32'(s_busy), 32'd1);
      for (int t = 1; t <= 6; t++) begin
         tick();
         chk("s_hdr_addr", 32'(s_hdr_addr), (t < 3) ? 32'(t) : 32'd3);
         chk("s_h_mem_we", 32'(s_mem_we), (t >= 2 && t <= 5) ? 32'd1 : 32'd0);
         if (t >= 2 && t <= 5) begin
            chk("s_h_mem_addr", 32'(s_mem_addr), 32'(t - 2));
            chk("s_h_mem_din", 32'(s_mem_din), 32'((t - 2) ^ 8'hA0));
         end
         chk("s_header_done", 32'(s_header_done), (t >= 6) ? 32'd1 : 32'd0);
      end
      for (int i = 0; i < 6; i++) begin
         for (int g = 0; g < gaps[i]; g++) begin
            s_pixel_valid = 1'b0;
            tick();
            chk("s_gap_mem_we", 32'(s_mem_we), 32'd0);
         end
         s_pixel_valid = 1'b1;
         s_pixel_in = vals[i];
         tick();
         chk("s_p_mem_we", 32'(s_mem_we), 32'd1);
         chk("s_p_mem_addr", 32'(s_mem_addr), 32'(4 + i));
         chk("s_p_mem_din", 32'(s_mem_din), 32'(vals[i]));
      end
      for (int k = 0; k < 3; k++) begin
         s_pixel_valid = 1'b1;
         s_pixel_in = 8'h11;
         tick();
         chk("s_ovr_mem_we", 32'(s_mem_we), 32'd0);
         chk("s_ovr_write_done", 32'(s_write_done), 32'd1);
         chk("s_ovr_busy", 32'(s_busy), 32'd0);
      end
      s_pixel_valid = 1'b0;

      // full frame at defaults, with an ignored second start at hdr_addr=500
      run_header(500);
      run_pixels();

      // restart from DONE; pixel_valid held high through the header copy
      pixel_valid = 1'b1;
      pixel_in = 8'h77;
      run_header(0);
      run_pixels();

      // reset mid-header, then reset together with start, then a fresh header copy
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 800; k++) begin
         tick();
      end
      chk("mr_hdr_addr", 32'(hdr_addr), 32'd800);
      chk("mr_mem_we", 32'(mem_we), 32'd1);
      rst_n = 1'b0;
      tick();
      chk_zero("mid_rst");
      start = 1'b1;
      tick();
      chk_zero("rst_start");
      rst_n = 1'b1;
      start = 1'b0;
      tick();
      chk_zero("post_rst");
      run_header(0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
